serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/adder_pkg.sv | 13 +
 rtl/fa_cell.sv | 13 +
 rtl/serial_adder.sv | 115 +++++++++++
 tb/tb_serial_adder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared FSM state encoding and add/subtract mode constants
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - single-bit combinational full adder
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor, LSB first, one full-adder cell
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_co;
  logic             accept, last_bit;

  fa_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign accept   = (state_q == ST_IDLE) && in_valid;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_bit)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    sum       = sum_q;
    cout      = carry_q;
    ovf       = ovf_q;
  end

  // Subtract is A + ~B + 1, so B is inverted at capture and the carry seeded to 1.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (accept) begin
      a_d     = a;
      b_d     = (sub == MODE_SUB) ? ~b : b;
      carry_d = (sub == MODE_SUB) ? 1'b1 : cin;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      a_d              = a_q >> 1;
      b_d              = b_q >> 1;
      sum_d            = sum_q >> 1;
      sum_d[WIDTH-1]   = fa_s;
      carry_d          = fa_co;
      cnt_d            = cnt_q + CW'(1);
      if (last_bit) begin
        ovf_d = carry_q ^ fa_co;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;

  typedef struct {
    int         dut;
    int         width;
    int         acc;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst8_n, rst1_n;
  logic       valid_d, or_d, cin_d, sub_d;
  logic [7:0] a_d, b_d;
  int         sel;
  bit         rand_or;

  logic       iv8, ir8, ov8, co8, of8;
  logic [7:0] s8;
  logic       iv1, ir1, ov1, co1, of1;
  logic [0:0] s1;

  logic       ov[2], ir[2], co[2], vf[2];
  logic [7:0] so[2];

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  assign iv8 = valid_d && (sel == 0);
  assign iv1 = valid_d && (sel == 1);
  assign ov[0] = ov8;
  assign ov[1] = ov1;
  assign ir[0] = ir8;
  assign ir[1] = ir1;
  assign co[0] = co8;
  assign co[1] = co1;
  assign vf[0] = of8;
  assign vf[1] = of1;
  assign so[0] = s8;
  assign so[1] = {7'b0, s1};

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8),
    .a(a_d), .b(b_d), .cin(cin_d), .sub(sub_d),
    .out_valid(ov8), .out_ready(or_d), .sum(s8), .cout(co8), .ovf(of8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .in_valid(iv1), .in_ready(ir1),
    .a(a_d[0:0]), .b(b_d[0:0]), .cin(cin_d), .sub(sub_d),
    .out_valid(ov1), .out_ready(or_d), .sum(s1), .cout(co1), .ovf(of1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: unsigned sum for sum/cout, signed arithmetic range test for ovf.
  function automatic exp_t model(input int d, input int w, input logic [7:0] av, input logic [7:0] bv,
                                 input logic ci, input logic sb);
    exp_t   e;
    longint mask, x, y, full, half, sx, sy, r;
    mask = (longint'(1) << w) - 1;
    x    = longint'(av) & mask;
    y    = longint'(bv) & mask;
    full = sb ? (x + ((~y) & mask) + 1) : (x + y + (ci ? 1 : 0));
    half = longint'(1) << (w - 1);
    sx   = (x >= half) ? x - 2 * half : x;
    sy   = (y >= half) ? y - 2 * half : y;
    r    = sb ? (sx - sy) : (sx + sy + (ci ? 1 : 0));
    e.dut   = d;
    e.width = w;
    e.acc   = 0;
    e.sum   = 8'(full & mask);
    e.cout  = ((full >> w) & 1) != 0;
    e.ovf   = (r < -half) || (r >= half);
    return e;
  endfunction

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send(input int d, input logic [7:0] av, input logic [7:0] bv,
                      input logic ci, input logic sb, input bit wait_res);
    exp_t e;
    int   n = 0;
    @(posedge clk); #1;
    sel = d; a_d = av; b_d = bv; cin_d = ci; sub_d = sb; valid_d = 1'b1;
    forever begin
      @(negedge clk);
      if (ir[d] || n > 50) break;
      n++;
    end
    chk("accept_seen", 64'(ir[d]), 64'd1);
    e = model(d, (d == 0) ? 8 : 1, av, bv, ci, sb);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (!wait_res) begin
      valid_d = 1'b0;
      return;
    end
    // Operands and in_valid thrash while busy; the DUT must ignore them.
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      a_d = 8'($urandom); b_d = 8'($urandom);
      cin_d = 1'($urandom); sub_d = 1'($urandom); valid_d = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    valid_d = 1'b0;
    chk("result_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_or) or_d = ($urandom % 4) != 0;
  end

  initial begin : monitor
    bit         ov_prev[2];
    bit         hs_prev[2];
    logic [7:0] sum_prev[2];
    logic       co_prev[2], vf_prev[2];
    int         first_cyc[2];
    exp_t       e;
    for (int d = 0; d < 2; d++) begin
      ov_prev[d] = 0; hs_prev[d] = 0; first_cyc[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (ov[d]) begin
          if (!ov_prev[d]) begin
            first_cyc[d] = cyc;
            if (exp_q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
          end else if (!hs_prev[d]) begin
            chk("hold_sum", 64'(so[d]), 64'(sum_prev[d]));
            chk("hold_cout", 64'(co[d]), 64'(co_prev[d]));
            chk("hold_ovf", 64'(vf[d]), 64'(vf_prev[d]));
          end
          chk("in_ready_in_done", 64'(ir[d]), 64'd0);
          if (or_d && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("dut_id", 64'(d), 64'(e.dut));
            chk("sum", 64'(so[d]), 64'(e.sum));
            chk("cout", 64'(co[d]), 64'(e.cout));
            chk("ovf", 64'(vf[d]), 64'(e.ovf));
            chk("latency", 64'(first_cyc[d] - e.acc + 1), 64'(e.width + 1));
          end
        end
        ov_prev[d]  = ov[d];
        hs_prev[d]  = ov[d] && or_d;
        sum_prev[d] = so[d];
        co_prev[d]  = co[d];
        vf_prev[d]  = vf[d];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   n;
    rst8_n = 1'b0; rst1_n = 1'b0; valid_d = 1'b0; or_d = 1'b1; rand_or = 0;
    sel = 0; a_d = '0; b_d = '0; cin_d = 1'b0; sub_d = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", 64'(ov[d]), 64'd0);
      chk("rst_sum", 64'(so[d]), 64'd0);
      chk("rst_cout", 64'(co[d]), 64'd0);
      chk("rst_ovf", 64'(vf[d]), 64'd0);
    end

    // Operand presented so it meets the first rising edge after release.
    @(posedge clk); #1;
    rst8_n = 1'b1; rst1_n = 1'b1;
    a_d = 8'h0F; b_d = 8'h01; cin_d = 1'b0; sub_d = 1'b0; valid_d = 1'b1;
    chk("in_ready_after_release", 64'(ir[0]), 64'd1);
    e = model(0, 8, 8'h0F, 8'h01, 1'b0, 1'b0);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    valid_d = 1'b0;
    @(negedge clk);
    chk("accepted_first_edge", 64'(ir[0]), 64'd0);
    wait_drain();

    send(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1);
    send(0, 8'h7F, 8'h01, 1'b0, 1'b0, 1);
    send(0, 8'h05, 8'h07, 1'b1, 1'b1, 1);
    send(0, 8'h80, 8'h01, 1'b0, 1'b1, 1);
    send(0, 8'h00, 8'h00, 1'b0, 1'b1, 1);

    rand_or = 1;
    for (int i = 0; i < 30; i++) begin
      send(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1);
    end

    // Backpressure: result held for five cycles with new in_valid offered.
    rand_or = 0; or_d = 1'b0;
    send(0, 8'h3C, 8'h5A, 1'b1, 1'b0, 0);
    n = 0;
    while (!ov[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reached_done", 64'(ov[0]), 64'd1);
    repeat (5) begin
      @(posedge clk); #1;
      sel = 0; valid_d = 1'b1; a_d = 8'($urandom); b_d = 8'($urandom);
    end
    @(negedge clk);
    chk("bp_still_valid", 64'(ov[0]), 64'd1);
    @(posedge clk); #1;
    valid_d = 1'b0; or_d = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_back_idle_ready", 64'(ir[0]), 64'd1);
    chk("bp_back_idle_valid", 64'(ov[0]), 64'd0);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Abort mid-RUN: nothing may be presented for the killed operation.
    rand_or = 1;
    send(0, 8'h55, 8'h22, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst8_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_out_valid", 64'(ov[0]), 64'd0);
    chk("abort_in_ready", 64'(ir[0]), 64'd1);
    chk("abort_sum", 64'(so[0]), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst8_n = 1'b1;
    repeat (15) @(negedge clk);
    send(0, 8'h01, 8'h02, 1'b0, 1'b0, 1);

    for (int i = 0; i < 8; i++) begin
      send(1, 8'((i >> 2) & 1), 8'((i >> 1) & 1), 1'(i & 1), 1'b0, 1);
    end
    for (int i = 0; i < 8; i++) begin
      send(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
